// File: rtl/aig_eval_pkg.sv
// Shared types and literal helpers for the AIG truth-table extractor.
// Holds the FSM state enum, default widths and the input-pattern generator.
package aig_eval_pkg;

    localparam int DEF_NUM_INPUTS = 3;
    localparam int DEF_MAX_ANDS   = 32;
    localparam int DEF_TT_W       = 2 ** DEF_NUM_INPUTS;
    localparam int DEF_LIT_W      = $clog2(2 * (DEF_NUM_INPUTS + DEF_MAX_ANDS + 1));
    // Widest truth table in_pattern can describe (NUM_INPUTS up to 8).
    localparam int MAX_TT_W       = 256;

    typedef enum logic [1:0] {
        LOAD,
        EVAL,
        DONE
    } state_t;

    function automatic int unsigned lit_var(input int unsigned lit);
        return lit >> 1;
    endfunction

    function automatic logic lit_neg(input int unsigned lit);
        return lit[0];
    endfunction

    // Primary input j (1-based) is true in minterm m when bit (j-1) of m is set.
    function automatic logic [MAX_TT_W-1:0] in_pattern(input int unsigned j);
        logic [MAX_TT_W-1:0] p;
        p = '0;
        if (j != 0 && j <= 8) begin
            for (int m = 0; m < MAX_TT_W; m++) begin
                p[m] = 1'((m >> (j - 1)) & 1);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/aig_node_store.sv
// Node fanin storage and per-node truth-table values for the extractor.
// One node write port, one value write port, three combinational literal-value reads.
module aig_node_store
    import aig_eval_pkg::*;
#(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int MAX_ANDS   = DEF_MAX_ANDS,
    parameter int TT_W       = DEF_TT_W,
    parameter int LIT_W      = DEF_LIT_W,
    parameter int IDX_W      = 5,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             node_we,
    input  logic [IDX_W-1:0] node_waddr,
    input  logic [LIT_W-1:0] node_wlit0,
    input  logic [LIT_W-1:0] node_wlit1,
    input  logic             val_we,
    input  logic [IDX_W-1:0] eval_idx,
    input  logic [TT_W-1:0]  val_wdata,
    input  logic [CNT_W-1:0] limit,
    input  logic [LIT_W-1:0] out_lit,
    output logic [TT_W-1:0]  fanin_tt0,
    output logic [TT_W-1:0]  fanin_tt1,
    output logic [TT_W-1:0]  out_tt
);

    logic [LIT_W-1:0] lit0_mem [MAX_ANDS];
    logic [LIT_W-1:0] lit1_mem [MAX_ANDS];
    logic [TT_W-1:0]  val_mem  [MAX_ANDS];

    // NOTE: storage arrays carry no reset; readers never look past the valid node count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with <= so every read in this edge sees old values.
        if (node_we) begin
            lit0_mem[node_waddr] <= node_wlit0;
            lit1_mem[node_waddr] <= node_wlit1;
        end
        if (val_we) begin
            val_mem[eval_idx] <= val_wdata;
        end
    end

    // Nodes at or beyond lim are not evaluated yet (or never existed) and read as 0.
    function automatic logic [TT_W-1:0] lit_value(input logic [LIT_W-1:0] lit,
                                                  input logic [CNT_W-1:0] lim);
        int unsigned         v;
        int unsigned         node;
        logic [MAX_TT_W-1:0] pat;
        logic [TT_W-1:0]     base;
        logic                ok;
        v    = lit_var(32'(lit));
        node = v - 32'(NUM_INPUTS) - 1;
        pat  = in_pattern(v);
        base = '0;
        ok   = 1'b1;
        if (v == 0) begin
            base = '0;
        end else if (v <= 32'(NUM_INPUTS)) begin
            base = pat[TT_W-1:0];
        end else if (node < 32'(lim)) begin
            base = val_mem[IDX_W'(node)];
        end else begin
            ok = 1'b0;
        end
        return ok ? (base ^ {TT_W{lit_neg(32'(lit))}}) : '0;
    endfunction

    always_comb begin
        fanin_tt0 = lit_value(lit0_mem[eval_idx], limit);
        fanin_tt1 = lit_value(lit1_mem[eval_idx], limit);
        out_tt    = lit_value(out_lit, limit);
    end

endmodule

// File: rtl/aig_tt_extractor.sv
// Streams an AIG netlist in, evaluates one AND node per cycle bit-parallel over all
// minterms, and returns the truth table of the chosen output literal.
module aig_tt_extractor
    import aig_eval_pkg::*;
#(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int MAX_ANDS   = DEF_MAX_ANDS,
    parameter int TT_W       = 2 ** NUM_INPUTS,
    parameter int LIT_W      = $clog2(2 * (NUM_INPUTS + MAX_ANDS + 1))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             node_valid,
    output logic             node_ready,
    input  logic [LIT_W-1:0] node_lit0,
    input  logic [LIT_W-1:0] node_lit1,
    input  logic             node_last,
    input  logic [LIT_W-1:0] out_lit,
    output logic             tt_valid,
    input  logic             tt_ready,
    output logic [TT_W-1:0]  tt_data,
    output logic             tt_err
);

    localparam int CNT_W = $clog2(MAX_ANDS + 1);
    localparam int IDX_W = (MAX_ANDS > 1) ? $clog2(MAX_ANDS) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] idx;
    logic             err;
    logic [LIT_W-1:0] out_lit_q;

    logic             accept;
    logic             full;
    logic             beat_err;
    logic             eval_last;
    logic             val_we;
    int unsigned      own_var;
    int unsigned      cur_var;
    int unsigned      cnt_final;
    logic [TT_W-1:0]  fanin_tt0;
    logic [TT_W-1:0]  fanin_tt1;
    logic [TT_W-1:0]  out_tt;
    logic [TT_W-1:0]  new_val;
    logic [TT_W-1:0]  result;

    assign accept = node_valid && node_ready;
    assign val_we = (state == EVAL) && (32'(idx) < 32'(cnt));

    always_comb begin
        // NOTE: every variable here is assigned before any conditional use, so no latch is inferred.
        own_var   = 32'(NUM_INPUTS) + 32'(cnt) + 1;
        full      = (32'(cnt) == 32'(MAX_ANDS));
        cnt_final = full ? 32'(cnt) : 32'(cnt) + 1;
        beat_err  = 1'b0;
        if (full) begin
            beat_err = 1'b1;
        end else if (lit_var(32'(node_lit0)) >= own_var || lit_var(32'(node_lit1)) >= own_var) begin
            beat_err = 1'b1;
        end
        if (node_last && lit_var(32'(out_lit)) > 32'(NUM_INPUTS) + cnt_final) begin
            beat_err = 1'b1;
        end

        // The output may name the node being computed this cycle; forward it so the
        // result can be registered on the final evaluation cycle.
        cur_var   = 32'(NUM_INPUTS) + 32'(idx) + 1;
        eval_last = (32'(idx) + 1 >= 32'(cnt));
        new_val   = fanin_tt0 & fanin_tt1;
        result    = out_tt;
        if (lit_var(32'(out_lit_q)) == cur_var) begin
            result = new_val ^ {TT_W{lit_neg(32'(out_lit_q))}};
        end
    end

    aig_node_store #(
        .NUM_INPUTS (NUM_INPUTS),
        .MAX_ANDS   (MAX_ANDS),
        .TT_W       (TT_W),
        .LIT_W      (LIT_W),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W)
    ) u_store (
        .clk        (clk),
        .node_we    (accept && !full),
        .node_waddr (IDX_W'(cnt)),
        .node_wlit0 (node_lit0),
        .node_wlit1 (node_lit1),
        .val_we     (val_we),
        .eval_idx   (IDX_W'(idx)),
        .val_wdata  (new_val),
        .limit      (idx),
        .out_lit    (out_lit_q),
        .fanin_tt0  (fanin_tt0),
        .fanin_tt1  (fanin_tt1),
        .out_tt     (out_tt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            cnt        <= '0;
            idx        <= '0;
            err        <= 1'b0;
            out_lit_q  <= '0;
            node_ready <= 1'b1;
            tt_valid   <= 1'b0;
            tt_data    <= '0;
            tt_err     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (!full) cnt <= cnt + 1'b1;
                        if (beat_err) err <= 1'b1;
                        if (node_last) begin
                            out_lit_q  <= out_lit;
                            idx        <= '0;
                            node_ready <= 1'b0;
                            state      <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    idx <= idx + 1'b1;
                    if (eval_last) begin
                        tt_data  <= result;
                        tt_err   <= err;
                        tt_valid <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (tt_ready) begin
                        cnt        <= '0;
                        err        <= 1'b0;
                        tt_valid   <= 1'b0;
                        node_ready <= 1'b1;
                        state      <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
